// File: rtl/sync_down_counter_pkg.sv
// rtl/sync_down_counter_pkg.sv - shared types for the loadable down-counter/timer
package sync_down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/sync_down_counter_if.sv
// rtl/sync_down_counter_if.sv - load handshake, control and status bundle of the down-counter
interface sync_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output load_valid, load_value, auto_reload, en, abort,
        input  load_ready, q, busy, tc, done
    );

    modport slave (
        input  load_valid, load_value, auto_reload, en, abort,
        output load_ready, q, busy, tc, done
    );
endinterface

// File: rtl/sync_down_counter_dff_en_rn.sv
// rtl/sync_down_counter_dff_en_rn.sv - W-bit register with load enable and async active-low clear
module dff_en_rn #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable down-counter/timer with one-shot and auto-reload modes
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sync_down_counter_if.slave   bus
);
    state_t           state_q, state_d;
    logic             accept, zero_load;
    logic             q_en, tc_d;
    logic [WIDTH-1:0] q_q, q_d, rld_q;
    logic             mode_q;
    logic             tc_q, done_q;
    logic             q_is_one, q_is_zero;

    assign bus.load_ready = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy       = (state_q == RUN);
    assign bus.q          = q_q;
    assign bus.tc         = tc_q;
    assign bus.done       = done_q;

    assign accept    = bus.load_valid && bus.load_ready;
    assign zero_load = accept && (bus.load_value == '0);
    assign q_is_one  = (q_q == WIDTH'(1));
    assign q_is_zero = (q_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_en    = 1'b0;
        q_d     = q_q;
        tc_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    q_en    = 1'b1;
                    q_d     = bus.load_value;
                    tc_d    = zero_load;
                    state_d = zero_load ? DONE : RUN;
                end else if (state_q == DONE && bus.abort) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    q_en    = 1'b1;
                    q_d     = '0;
                end else if (bus.en) begin
                    q_en = 1'b1;
                    tc_d = q_is_one;
                    // q only sits at 0 in RUN when auto-reload is active
                    if (!q_is_zero) begin
                        q_d = q_q - WIDTH'(1);
                    end else if (mode_q) begin
                        q_d = rld_q;
                    end
                    if (q_is_one && !mode_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                q_en    = 1'b1;
                q_d     = '0;
            end
        endcase
    end

    dff_en_rn #(.W(WIDTH)) u_q (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (q_en),
        .d     (q_d),
        .q     (q_q)
    );

    dff_en_rn #(.W(WIDTH)) u_rld (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .d     (bus.load_value),
        .q     (rld_q)
    );

    dff_en_rn #(.W(1)) u_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .d     (bus.auto_reload),
        .q     (mode_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tc_q   <= tc_d;
            done_q <= (state_d == DONE);
        end
    end
endmodule

// File: tb/tb_sync_down_counter.sv
// tb/tb_sync_down_counter.sv - scoreboard bench for sync_down_counter (WIDTH=4)
module tb_sync_down_counter;
    logic clk = 1'b0;
    logic rst_n;

    sync_down_counter_if #(.WIDTH(4)) bus ();

    sync_down_counter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // expected word: {q[3:0], tc, done, busy, load_ready}
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    event       sample_now;

    initial begin : monitor
        logic [7:0] got, exp;
        string      nm;
        forever begin
            @(negedge clk or sample_now);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {bus.q, bus.tc, bus.done, bus.busy, bus.load_ready};
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL %s: got q=%0d tc=%b done=%b busy=%b rdy=%b, required q=%0d tc=%b done=%b busy=%b rdy=%b",
                             nm, got[7:4], got[3], got[2], got[1], got[0],
                             exp[7:4], exp[3], exp[2], exp[1], exp[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic push(input string nm, input logic [3:0] eq, input logic etc,
                        input logic edone, input logic ebusy, input logic erdy);
        exp_q.push_back({eq, etc, edone, ebusy, erdy});
        name_q.push_back(nm);
    endtask

    // drive inputs just after a falling edge, expect the state after the next rising edge
    task automatic step(input logic lv, input logic [3:0] lval, input logic ar,
                        input logic e, input logic ab, input string nm,
                        input logic [3:0] eq, input logic etc, input logic edone,
                        input logic ebusy, input logic erdy);
        bus.load_valid  = lv;
        bus.load_value  = lval;
        bus.auto_reload = ar;
        bus.en          = e;
        bus.abort       = ab;
        @(posedge clk);
        #1;
        push(nm, eq, etc, edone, ebusy, erdy);
        @(negedge clk);
    endtask

    task automatic expect_now(input string nm, input logic [3:0] eq, input logic etc,
                              input logic edone, input logic ebusy, input logic erdy);
        push(nm, eq, etc, edone, ebusy, erdy);
        ->sample_now;
        #1;
    endtask

    localparam logic [3:0] EN_T4 [6] = '{1, 0, 1, 0, 1, 1};
    localparam logic [3:0] Q_T4  [6] = '{3, 3, 2, 2, 1, 0};

    initial begin : stim
        rst_n           = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_value  = '0;
        bus.auto_reload = 1'b0;
        bus.en          = 1'b0;
        bus.abort       = 1'b0;
        repeat (2) @(negedge clk);
        expect_now("reset_state", 0, 0, 0, 0, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: asynchronous reset mid-count
        step(1, 5, 0, 1, 0, "t1_load5", 5, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t1_q4",    4, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t1_q3",    3, 0, 0, 1, 0);
        rst_n = 1'b0;
        #2;
        expect_now("t1_async_reset", 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: one-shot load 3
        step(1, 3, 0, 1, 0, "t2_load3", 3, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t2_q2",    2, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t2_q1",    1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t2_q0_tc", 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 0, "t2_done",  0, 0, 1, 0, 1);

        // 3: auto-reload load 2 from DONE, then abort from RUN
        step(1, 2, 1, 1, 0, "t3_load2", 2, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t3_q1a",   1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t3_q0a",   0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t3_rld_a", 2, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t3_q1b",   1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t3_q0b",   0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t3_rld_b", 2, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, "t3_abort", 0, 0, 0, 0, 1);

        // 4: gated enable, then hold at 0
        step(1, 4, 0, 0, 0, "t4_load4", 4, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, EN_T4[i][0], 0, $sformatf("t4_en%0d", i),
                 Q_T4[i], (i == 5), (i == 5), (i != 5), (i == 5));
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, $sformatf("t4_hold%0d", i), 0, 0, 1, 0, 1);
        end

        // 5: load during RUN ignored, abort wins over en
        step(1, 6, 0, 1, 0, "t5_load6", 6, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t5_q5",    5, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t5_q4",    4, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t5_q3",    3, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, "t5_q2",    2, 0, 0, 1, 0);
        step(1, 9, 0, 0, 0, "t5_ld_ign", 2, 0, 0, 1, 0);
        step(1, 9, 0, 1, 1, "t5_abort", 0, 0, 0, 0, 1);
        bus.load_valid = 1'b0;
        step(0, 0, 0, 1, 1, "t5_idle_abort", 0, 0, 0, 0, 1);

        // 6: zero load, then full-scale load 15
        step(1, 0, 0, 0, 0, "t6_load0",  0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, "t6_done0",  0, 0, 1, 0, 1);
        step(1, 15, 0, 1, 0, "t6_load15", 15, 0, 0, 1, 0);
        for (int i = 14; i >= 0; i--) begin
            step(0, 0, 0, 1, 0, $sformatf("t6_q%0d", i),
                 4'(i), (i == 0), (i == 0), (i != 0), (i == 0));
        end

        // DONE: load and abort on the same edge -> load wins; abort alone -> IDLE
        step(1, 2, 0, 0, 1, "t7_load_wins", 2, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, "t7_run_abort", 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, "t7_load0_auto", 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1, "t7_done_abort", 0, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
